// File: rtl/print_uart_tx_pkg.sv
// Shared definitions for the print UART: FSM states, ASCII constants and the hex-digit encoder.
package print_uart_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StStop
    } state_e;

    localparam logic [7:0] Ascii0  = 8'h30;
    localparam logic [7:0] AsciiA  = 8'h41;
    localparam logic [7:0] AsciiLf = 8'h0A;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return Ascii0 + {4'h0, nib};
        end
        return AsciiA + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/print_uart_tx_fifo.sv
// Small synchronous FIFO buffering print words; dout shows the head entry while !empty.
module print_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;
    logic              do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/print_uart_tx.sv
// Buffers CPU print words and sends each as 8 uppercase hex digits plus LF on a UART 8N1 line.
module print_uart_tx
    import print_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              print_valid,
    input  logic [DATA_W-1:0] print_data,
    output logic              print_ready,
    output logic              uart_tx,
    output logic              busy,
    output logic [7:0]        drop_count
);
    localparam int unsigned NumNibbles = DATA_W / 4;
    localparam int unsigned CharIdxW   = $clog2(NumNibbles + 1);
    localparam int unsigned BaudW      = $clog2(CLKS_PER_BIT);

    state_e              state_q, state_d;
    logic [BaudW-1:0]    baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [CharIdxW-1:0] char_idx_q, char_idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                uart_tx_q, uart_tx_d;
    logic [7:0]          drop_q, drop_d;

    logic              fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              baud_last;

    print_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (print_valid && !fifo_full),
        .pop   (fifo_pop),
        .din   (print_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            char_idx_q <= '0;
            shift_q    <= '0;
            tx_byte_q  <= '0;
            uart_tx_q  <= 1'b1;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            char_idx_q <= char_idx_d;
            shift_q    <= shift_d;
            tx_byte_q  <= tx_byte_d;
            uart_tx_q  <= uart_tx_d;
            drop_q     <= drop_d;
        end
    end

    assign baud_last = (baud_q == BaudW'(CLKS_PER_BIT - 1));
    assign drop_d    = (print_valid && fifo_full && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        char_idx_d = char_idx_q;
        shift_d    = shift_q;
        tx_byte_d  = tx_byte_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    char_idx_d = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                // Shifting left keeps the next digit in the top nibble.
                if (char_idx_q == CharIdxW'(NumNibbles)) begin
                    tx_byte_d = AsciiLf;
                end else begin
                    tx_byte_d = nibble_to_ascii(shift_q[DATA_W-1 -: 4]);
                end
                shift_d = shift_q << 4;
                baud_d  = '0;
                state_d = StStart;
            end
            StStart: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                baud_d = baud_q + 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (char_idx_q == CharIdxW'(NumNibbles)) begin
                        state_d = StIdle;
                    end else begin
                        char_idx_d = char_idx_q + 1'b1;
                        state_d    = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The line is registered, so it trails the state by one cycle.
    always_comb begin
        uart_tx_d = 1'b1;
        unique case (state_q)
            StStart: uart_tx_d = 1'b0;
            StData:  uart_tx_d = tx_byte_q[bit_q];
            default: uart_tx_d = 1'b1;
        endcase
    end

    assign uart_tx     = uart_tx_q;
    assign busy        = (state_q != StIdle) || !fifo_empty;
    assign print_ready = !fifo_full;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_print_uart_tx.sv
// Randomised self-checking bench for print_uart_tx against a line-level timeline model.
module tb_print_uart_tx;
    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int WORD_CYCLES = 9 * (10 * C + 1);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        print_valid = 1'b0;
    logic [31:0] print_data = '0;
    logic        print_ready, uart_tx, busy;
    logic [7:0]  drop_count;

    print_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH),
        .DATA_W       (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .print_valid (print_valid),
        .print_data  (print_data),
        .print_ready (print_ready),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq[$];
    bit          txq[$];
    logic [7:0]  emitted[$];
    int          fsm_rem = 0;
    logic [7:0]  m_drop = '0;
    logic        m_full;
    logic [31:0] m_word;
    logic        exp_tx_now = 1'b1, exp_busy = 1'b0, exp_ready = 1'b1;
    logic        model_live = 1'b0;

    function automatic logic [7:0] hexc(input logic [3:0] v);
        return (v < 4'd10) ? 8'h30 + 8'(v) : 8'h37 + 8'(v);
    endfunction

    // Each char: one idle-high cycle, C start, 8*C data LSB first, C stop.
    task automatic emit_word(input logic [31:0] w);
        logic [7:0] ch;
        for (int k = 0; k < 9; k++) begin
            ch = (k < 8) ? hexc(4'((w >> (28 - 4 * k)) & 32'hF)) : 8'h0A;
            emitted.push_back(ch);
            txq.push_back(1'b1);
            for (int i = 0; i < C; i++) txq.push_back(1'b0);
            for (int b = 0; b < 8; b++)
                for (int i = 0; i < C; i++) txq.push_back(ch[b]);
            for (int i = 0; i < C; i++) txq.push_back(1'b1);
        end
    endtask

    initial forever begin
        @(posedge clock);
        if (reset) begin
            mq.delete();
            txq.delete();
            fsm_rem    = 0;
            m_drop     = '0;
            exp_tx_now = 1'b1;
        end else begin
            m_full = (mq.size() == DEPTH);
            if (txq.size() > 0) exp_tx_now = txq.pop_front();
            else                exp_tx_now = 1'b1;
            if (fsm_rem == 0 && mq.size() > 0) begin
                m_word = mq.pop_front();
                emit_word(m_word);
                fsm_rem = WORD_CYCLES;
            end else if (fsm_rem > 0) begin
                fsm_rem--;
            end
            if (print_valid) begin
                if (!m_full)               mq.push_back(print_data);
                else if (m_drop != 8'hFF)  m_drop++;
            end
        end
        exp_busy   = (fsm_rem != 0) || (mq.size() != 0);
        exp_ready  = (mq.size() < DEPTH);
        model_live = 1'b1;
    end

    initial forever begin
        @(negedge clock);
        if (model_live) begin
            check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx_now});
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("print_ready", {31'd0, print_ready}, {31'd0, exp_ready});
            check("drop_count", {24'd0, drop_count}, {24'd0, m_drop});
        end
    end

    // ---------------- UART receiver ----------------
    logic [7:0] rx_q[$];
    logic       dec_on = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte;

    initial forever begin
        @(negedge clock);
        if (reset) begin
            dec_on = 1'b0;
        end else if (!dec_on) begin
            if (uart_tx === 1'b0) begin
                dec_on  = 1'b1;
                dec_cnt = 0;
            end
        end else begin
            dec_cnt++;
            for (int b = 1; b <= 8; b++)
                if (dec_cnt == b * C + C / 2) dec_byte[b-1] = uart_tx;
            if (dec_cnt == 9 * C + C / 2) begin
                check("stop_bit", {31'd0, uart_tx}, 32'd1);
                rx_q.push_back(dec_byte);
                dec_on = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        print_valid = 1'b1;
        print_data  = w;
        step();
        print_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            step();
            k++;
        end
        check(name, {31'd0, busy}, 32'd0);
        repeat (12) step();
    endtask

    task automatic compare_rx(input string name);
        check({name, "_count"}, rx_q.size(), emitted.size());
        for (int i = 0; i < rx_q.size() && i < emitted.size(); i++)
            check({name, "_byte"}, {24'd0, rx_q[i]}, {24'd0, emitted[i]});
    endtask

    task automatic clear_rx();
        rx_q.delete();
        emitted.delete();
    endtask

    logic [7:0]  exp2[9] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h33, 8'h37, 8'h0A};
    logic [7:0]  exp3[9] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
    logic [31:0] w4[6]   = '{32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF,
                             32'h00000000, 32'hCAFEF00D, 32'h55555555};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            step();
            check("t1_tx", {31'd0, uart_tx}, 32'd1);
            check("t1_ready", {31'd0, print_ready}, 32'd1);
            check("t1_busy", {31'd0, busy}, 32'd0);
            check("t1_drop", {24'd0, drop_count}, 32'd0);
        end

        // Single small word
        clear_rx();
        push_word(32'h0000_0037);
        wait_idle(1000, "t2_drain");
        check("t2_count", rx_q.size(), 9);
        for (int i = 0; i < rx_q.size() && i < 9; i++)
            check("t2_byte", {24'd0, rx_q[i]}, {24'd0, exp2[i]});
        compare_rx("t2_model");

        // Letters A-F
        clear_rx();
        push_word(32'hDEAD_BEEF);
        wait_idle(1000, "t3_drain");
        check("t3_count", rx_q.size(), 9);
        for (int i = 0; i < rx_q.size() && i < 9; i++)
            check("t3_byte", {24'd0, rx_q[i]}, {24'd0, exp3[i]});
        compare_rx("t3_model");

        // Six back-to-back words into a depth-4 FIFO
        clear_rx();
        print_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            print_data = w4[i];
            if (i == 5) begin
                @(negedge clock);
                check("t4_ready_w5", {31'd0, print_ready}, 32'd0);
            end
            step();
        end
        print_valid = 1'b0;
        check("t4_drop", {24'd0, drop_count}, 32'd1);
        wait_idle(4000, "t4_drain");
        check("t4_count", rx_q.size(), 45);
        if (rx_q.size() > 9) begin
            check("t4_first", {24'd0, rx_q[0]}, 32'h30);
            check("t4_second_word", {24'd0, rx_q[9]}, 32'h38);
        end
        compare_rx("t4_model");

        // Random sparse traffic
        clear_rx();
        for (int i = 0; i < 3000; i++) begin
            print_valid = ($urandom_range(0, 39) == 0);
            print_data  = $urandom;
            step();
        end
        print_valid = 1'b0;
        wait_idle(6000, "rand_drain");
        compare_rx("rand_model");

        // Reset during data bit 3 of char 2
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_rx();
        print_valid = 1'b1;
        print_data = 32'h1234_5678; step();
        print_data = 32'h0000_0009; step();
        print_data = 32'h0000_000A; step();
        print_valid = 1'b0;
        repeat (99) step();
        check("t5_bit3", {31'd0, uart_tx}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_tx_after_reset", {31'd0, uart_tx}, 32'd1);
        check("t5_busy_after_reset", {31'd0, busy}, 32'd0);
        repeat (500) step();
        check("t5_count", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            check("t5_byte0", {24'd0, rx_q[0]}, 32'h31);
            check("t5_byte1", {24'd0, rx_q[1]}, 32'h32);
        end

        // Saturating drop counter
        print_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            print_data = $urandom;
            step();
        end
        check("t6_drop_sat", {24'd0, drop_count}, 32'd255);
        repeat (20) step();
        check("t6_drop_hold", {24'd0, drop_count}, 32'd255);
        print_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("t6_drop_cleared", {24'd0, drop_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
